jtopl_pm_gen: RTL and testbench
===============================

Name: jtopl_pm_gen

Overview:
Self-contained vibrato (phase-modulation) generator for the OPL operator pipeline. It owns the vibrato LFO: a sample-rate prescaler plus a 3-bit vibrato step counter. It computes a signed per-slot pitch offset from the slot's F-number MSBs, the global depth bit and the per-slot vibrato enable. Output is pipelined so the phase generator can add it one stage later. Width of F-number, number of MSBs used and LFO period are parameters.

Parameters:
FNUM_W, 10, F-number width.
RANGE_W, 3, number of F-number MSBs forming the modulation range.
DIV_W, 10, LFO prescaler width; step period = 2^DIV_W samples.
OUT_W, RANGE_W+1, two's-complement output width (must be >= RANGE_W+1).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
cen  in  1  clock enable; all registers hold when low.
zero  in  1  sample-boundary strobe, one cen cycle per sample.
lfo_rst  in  1  test-register LFO reset; synchronous, clears prescaler and step counter.
vib_dep  in  1  global depth: 1 = full, 0 = half.
in_valid  in  1  slot data valid this cycle.
fnum  in  FNUM_W  slot F-number.
viben  in  1  slot vibrato enable.
out_valid  out  1  in_valid delayed two cen cycles.
pm_offset  out  OUT_W  signed pitch offset.
vib_cnt  out  3  current LFO step, for debug and the tremolo block.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler = 0, vib_cnt = 0, pipeline registers = 0, out_valid = 0, pm_offset = 0.
- LFO, evaluated only when cen = 1:
  - lfo_rst = 1: prescaler and vib_cnt clear. lfo_rst wins over zero.
  - Otherwise, when zero = 1: prescaler increments mod 2^DIV_W.
  - When the prescaler wraps from all-ones to 0: vib_cnt increments mod 8 (wraps 7 -> 0).
- Offset datapath, two stages, each advancing only on cen:
  - Stage 1 registers r and neg, where:
    - r = 0 if vib_cnt[1:0] == 0.
    - Otherwise r = fnum[FNUM_W-1 -: RANGE_W] >> vib_cnt[0], then >> 1 more if vib_dep = 0.
    - neg = vib_cnt[2].
    - viben = 0 forces r = 0.
    - Stage 1 uses the vib_cnt value present before any same-cycle update.
  - Stage 2 registers pm_offset = neg ? -zext(r) : zext(r), zero-extended to OUT_W. neg with r = 0 yields 0, never negative zero.
  - out_valid is in_valid delayed through the same two stages.
- Latency is fixed at 2 cen cycles from fnum/viben/in_valid to pm_offset/out_valid.
- in_valid does not gate the datapath; data flows every cen cycle. out_valid is only a qualifier.
- cen low for any duration: no state changes, and outputs hold their last values.
- The 8-step sequence over vib_cnt 0..7 is magnitude 0, r/2, r, r/2, 0, -r/2, -r, -r/2 (full depth). It is a triangle, symmetric about zero.

Optional Feature:
Macro JTOPL_PM_LFO_LOAD_EN.
- Defined: adds ports lfo_load (in, 1) and lfo_din (in, 3).
  - When cen = 1 and lfo_load = 1, vib_cnt <= lfo_din and the prescaler clears.
  - Priority: lfo_rst > lfo_load > normal count.
  - Used for fast verification and savestate restore.
- Not defined: the ports do not exist, and the LFO only counts or resets.

Decomposition:
- Shared package jtopl_pkg holds:
  - VIB_STEPS = 8.
  - Default widths FNUM_W = 10, DIV_W = 10.
  - A function for the range shift so the tremolo and phase blocks share one definition.
- One sub-module: jtopl_pm_lfo, containing the prescaler, vib_cnt, lfo_rst and optional load logic.
- The offset pipeline stays in the top module.

Test Plan:
- Reset release, then 1023 zero pulses with cen = 1 -> vib_cnt = 0. The 1024th pulse -> vib_cnt = 1. After 8192 pulses total -> vib_cnt = 0.
- fnum = 0x380, vib_dep = 1, viben = 1, with vib_cnt stepped 0..7 -> pm_offset sequence 0, 3, 7, 3, 0, 0xD, 0x9, 0xD (OUT_W = 4), each appearing 2 cen cycles after input.
- Same stimulus with vib_dep = 0 -> sequence 0, 1, 3, 1, 0, 0xF, 0xD, 0xF. With viben = 0 -> all 0.
- in_valid pulse with cen toggling 1, 0, 0, 1 -> out_valid rises only after the second cen-high cycle. Outputs stay frozen while cen = 0.
- lfo_rst and zero both asserted at prescaler = 1023, vib_cnt = 3 -> prescaler = 0 and vib_cnt = 0 next cycle.
- rst_n asserted mid-stream with pm_offset = 7 -> pm_offset = 0 and out_valid = 0 immediately, without a clock edge. With JTOPL_PM_LFO_LOAD_EN, lfo_load with lfo_din = 6 -> vib_cnt = 6 next cycle.

Source files
------------

// File: rtl/jtopl_pkg.sv
// -----------------------------------------------------------------------------
// jtopl_pkg
// Shared definitions for the OPL LFO consumers (vibrato, tremolo, phase).
//   VIB_STEPS    : number of vibrato LFO steps (one triangle period)
//   CNT_W        : width of the vibrato step counter
//   FNUM_W_DEF   : default F-number width
//   DIV_W_DEF    : default LFO prescaler width
//   vib_range()  : per-step shift of the F-number MSBs into a vibrato magnitude
// -----------------------------------------------------------------------------
package jtopl_pkg;

   localparam int VIB_STEPS  = 8;
   localparam int CNT_W      = $clog2(VIB_STEPS);
   localparam int FNUM_W_DEF = 10;
   localparam int DIV_W_DEF  = 10;

   // Magnitude of the vibrato deviation for one LFO step. Steps 0 and 4 are the
   // zero crossings of the triangle; odd steps are the half-way points, so they
   // take one extra right shift. Half depth shifts once more. The caller keeps
   // the low bits it needs, so one 16-bit definition serves every range width.
   function automatic logic [15:0] vib_range(input logic [15:0]      msbs,
                                             input logic [CNT_W-1:0] step,
                                             input logic             full_depth);
      logic [15:0] r;
      if (step[1:0] == 2'd0) begin
         r = '0;
      end else begin
         r = msbs >> step[0];
         if (!full_depth) r = r >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/jtopl_pm_lfo.sv
// -----------------------------------------------------------------------------
// jtopl_pm_lfo
// Vibrato LFO: a sample-rate prescaler and a step counter that advances each
// time the prescaler wraps (every 2^DIV_W samples).
// Optional feature macro: JTOPL_PM_LFO_LOAD_EN adds a direct step-counter load.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cen          : clock enable, all state holds when low
//   zero         : one-per-sample strobe, advances the prescaler
//   lfo_rst      : synchronous clear of prescaler and step counter
//   lfo_load     : (macro only) load vib_cnt from lfo_din, clear prescaler
//   lfo_din      : (macro only) value loaded into vib_cnt
//   vib_cnt      : current vibrato step
// -----------------------------------------------------------------------------
module jtopl_pm_lfo
   import jtopl_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic             zero,
   input  logic             lfo_rst,
`ifdef JTOPL_PM_LFO_LOAD_EN
   input  logic             lfo_load,
   input  logic [CNT_W-1:0] lfo_din,
`endif
   output logic [CNT_W-1:0] vib_cnt
);

   logic [DIV_W-1:0] prescaler;

   // Priority: lfo_rst, then load (when built in), then the normal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         vib_cnt   <= '0;
      end else if (cen) begin
         if (lfo_rst) begin
            prescaler <= '0;
            vib_cnt   <= '0;
         end
`ifdef JTOPL_PM_LFO_LOAD_EN
         else if (lfo_load) begin
            prescaler <= '0;
            vib_cnt   <= lfo_din;
         end
`endif
         else if (zero) begin
            prescaler <= prescaler + DIV_W'(1);
            // Step advances on the all-ones -> 0 wrap of the prescaler.
            if (&prescaler) vib_cnt <= vib_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/jtopl_pm_gen.sv
// -----------------------------------------------------------------------------
// jtopl_pm_gen
// Vibrato (phase-modulation) generator. Owns the vibrato LFO and turns each
// slot's F-number MSBs into a signed pitch offset, two cen cycles later.
// Optional feature macro: JTOPL_PM_LFO_LOAD_EN (adds lfo_load / lfo_din).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cen          : clock enable, all registers hold when low
//   zero         : sample-boundary strobe for the LFO prescaler
//   lfo_rst      : synchronous LFO clear
//   vib_dep      : 1 = full vibrato depth, 0 = half depth
//   in_valid     : slot data qualifier (does not gate the datapath)
//   fnum         : slot F-number
//   viben        : slot vibrato enable
//   lfo_load     : (macro only) load vib_cnt from lfo_din
//   lfo_din      : (macro only) LFO step to load
//   out_valid    : in_valid delayed two cen cycles
//   pm_offset    : signed (two's complement) pitch offset
//   vib_cnt      : current LFO step
// Valid/ready: there is no backpressure. in_valid is sampled on every cen
// cycle and reappears as out_valid exactly two cen cycles later, aligned with
// the pm_offset computed from the same fnum/viben.
// -----------------------------------------------------------------------------
module jtopl_pm_gen
   import jtopl_pkg::*;
#(
   parameter int FNUM_W  = FNUM_W_DEF,
   parameter int RANGE_W = 3,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int OUT_W   = RANGE_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   input  logic              zero,
   input  logic              lfo_rst,
   input  logic              vib_dep,
   input  logic              in_valid,
   input  logic [FNUM_W-1:0] fnum,
   input  logic              viben,
`ifdef JTOPL_PM_LFO_LOAD_EN
   input  logic              lfo_load,
   input  logic [CNT_W-1:0]  lfo_din,
`endif
   output logic              out_valid,
   output logic [OUT_W-1:0]  pm_offset,
   output logic [CNT_W-1:0]  vib_cnt
);

   jtopl_pm_lfo #(
      .DIV_W    (DIV_W)
   ) u_lfo (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .zero     (zero),
      .lfo_rst  (lfo_rst),
`ifdef JTOPL_PM_LFO_LOAD_EN
      .lfo_load (lfo_load),
      .lfo_din  (lfo_din),
`endif
      .vib_cnt  (vib_cnt)
   );

   logic [RANGE_W-1:0] msbs;
   logic [RANGE_W-1:0] r_next;
   logic [RANGE_W-1:0] r_q;
   logic               neg_q;
   logic               valid_q;

   assign msbs = fnum[FNUM_W-1 -: RANGE_W];

   // The low F-number bits do not contribute to the vibrato range.
   generate
      if (FNUM_W > RANGE_W) begin : g_low_bits
         logic unused_fnum_low;
         assign unused_fnum_low = ^fnum[FNUM_W-RANGE_W-1:0];
      end
   endgenerate

   // Stage 1 sees the registered vib_cnt, i.e. the step before any update
   // happening on this same edge.
   always_comb begin
      r_next = '0;
      if (viben) r_next = RANGE_W'(vib_range(16'(msbs), vib_cnt, vib_dep));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q       <= '0;
         neg_q     <= 1'b0;
         valid_q   <= 1'b0;
         pm_offset <= '0;
         out_valid <= 1'b0;
      end else if (cen) begin
         r_q       <= r_next;
         neg_q     <= vib_cnt[CNT_W-1];
         valid_q   <= in_valid;
         // Two's-complement negate of zero is zero, so no negative zero.
         pm_offset <= neg_q ? (OUT_W'(0) - OUT_W'(r_q)) : OUT_W'(r_q);
         out_valid <= valid_q;
      end
   end

endmodule

// File: tb/tb_jtopl_pm_gen.sv
// -----------------------------------------------------------------------------
// tb_jtopl_pm_gen
// Self-checking bench for jtopl_pm_gen with a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_jtopl_pm_gen;

   localparam int FNUM_W  = 10;
   localparam int RANGE_W = 3;
   localparam int DIV_W   = 10;
   localparam int OUT_W   = RANGE_W + 1;
   localparam int PERIOD  = 1 << DIV_W;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // stimulus
   logic              cen = 1'b0;
   logic              zero = 1'b0;
   logic              lfo_rst = 1'b0;
   logic              vib_dep = 1'b1;
   logic              in_valid = 1'b0;
   logic [FNUM_W-1:0] fnum = '0;
   logic              viben = 1'b0;
`ifdef JTOPL_PM_LFO_LOAD_EN
   logic              lfo_load = 1'b0;
   logic [2:0]        lfo_din = '0;
`endif

   logic              out_valid;
   logic [OUT_W-1:0]  pm_offset;
   logic [2:0]        vib_cnt;

   jtopl_pm_gen #(
      .FNUM_W   (FNUM_W),
      .RANGE_W  (RANGE_W),
      .DIV_W    (DIV_W),
      .OUT_W    (OUT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .zero     (zero),
      .lfo_rst  (lfo_rst),
      .vib_dep  (vib_dep),
      .in_valid (in_valid),
      .fnum     (fnum),
      .viben    (viben),
`ifdef JTOPL_PM_LFO_LOAD_EN
      .lfo_load (lfo_load),
      .lfo_din  (lfo_din),
`endif
      .out_valid(out_valid),
      .pm_offset(pm_offset),
      .vib_cnt  (vib_cnt)
   );

   int checks = 0;
   int errors = 0;

   // reference model: sample counter and pending outputs {valid, offset}
   int unsigned      m_samples;     // zero pulses since last LFO clear
   logic [OUT_W:0]   exp_q[$];
   logic [OUT_W-1:0] exp_off;
   logic             exp_val;

   function automatic int model_step();
      return (m_samples / PERIOD) % 8;
   endfunction

   // Triangle: 0, r/2, r, r/2, 0, -r/2, -r, -r/2 ; half depth halves again.
   function automatic logic [OUT_W-1:0] model_off(input int f, input int step,
                                                  input bit dep, input bit en);
      int r;
      int mag;
      r = f >> (FNUM_W - RANGE_W);
      case (step % 4)
         0:       mag = 0;
         2:       mag = r;
         default: mag = r / 2;
      endcase
      if (!dep) mag = mag / 2;
      if (!en) mag = 0;
      if (step >= 4) mag = -mag;
      return OUT_W'(mag);
   endfunction

   task automatic model_reset();
      m_samples = 0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_off = '0;
      exp_val = 1'b0;
   endtask

   // One clock edge; the model consumes the inputs the DUT sampled.
   task automatic tick();
      @(posedge clk);
      if (rst_n && cen) begin
         exp_q.push_back({in_valid, model_off(int'(fnum), model_step(), vib_dep, viben)});
         {exp_val, exp_off} = exp_q.pop_front();
         if (lfo_rst) m_samples = 0;
`ifdef JTOPL_PM_LFO_LOAD_EN
         else if (lfo_load) m_samples = int'(lfo_din) * PERIOD;
`endif
         else if (zero) m_samples = (m_samples + 1) % (8 * PERIOD);
      end
      #1;
   endtask

   task automatic idle_inputs();
      cen = 1'b1; zero = 1'b0; lfo_rst = 1'b0;
`ifdef JTOPL_PM_LFO_LOAD_EN
      lfo_load = 1'b0;
`endif
   endtask

   task automatic clear_lfo();
      idle_inputs();
      lfo_rst = 1'b1;
      tick();
      lfo_rst = 1'b0;
   endtask

   task automatic pulses(input int n);
      zero = 1'b1;
      for (int i = 0; i < n; i++) tick();
      zero = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #12 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (pm_offset !== '0) begin errors++; $display("FAIL reset_pm_offset got=%h exp=0", pm_offset); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (vib_cnt !== 3'd0) begin errors++; $display("FAIL reset_vib_cnt got=%0d exp=0", vib_cnt); end
   endtask

   task automatic test_lfo_count();
      idle_inputs();
      pulses(PERIOD - 1);
      checks++;
      if (vib_cnt !== 3'd0) begin errors++; $display("FAIL lfo_1023 got=%0d exp=0", vib_cnt); end
      pulses(1);
      checks++;
      if (vib_cnt !== 3'd1) begin errors++; $display("FAIL lfo_1024 got=%0d exp=1", vib_cnt); end
      pulses(7 * PERIOD - 1);
      checks++;
      if (vib_cnt !== 3'd7) begin errors++; $display("FAIL lfo_8191 got=%0d exp=7", vib_cnt); end
      pulses(1);
      checks++;
      if (vib_cnt !== 3'd0) begin errors++; $display("FAIL lfo_8192 got=%0d exp=0", vib_cnt); end
   endtask

   task automatic test_vib_sequence();
      logic [OUT_W-1:0] tab_full [8];
      logic [OUT_W-1:0] tab_half [8];
      tab_full = '{4'h0, 4'h3, 4'h7, 4'h3, 4'h0, 4'hD, 4'h9, 4'hD};
      tab_half = '{4'h0, 4'h1, 4'h3, 4'h1, 4'h0, 4'hF, 4'hD, 4'hF};
      clear_lfo();
      fnum = 10'h380;
      for (int s = 0; s < 8; s++) begin
         for (int c = 0; c < 3; c++) begin
            vib_dep = (c == 0); viben = (c != 2); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            checks++;
            if (pm_offset !== ((c == 0) ? tab_full[s] : (c == 1) ? tab_half[s] : '0)) begin
               errors++;
               $display("FAIL seq step=%0d cfg=%0d got=%h exp=%h", s, c, pm_offset,
                        (c == 0) ? tab_full[s] : (c == 1) ? tab_half[s] : '0);
            end
         end
         pulses(PERIOD);
      end
   endtask

   task automatic test_cen_hold();
      logic [OUT_W-1:0] held;
      idle_inputs();
      fnum = 10'h380; vib_dep = 1'b1; viben = 1'b1; in_valid = 1'b0;
      tick(); tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; cen = 1'b0;
      held = pm_offset;
      for (int i = 0; i < 2; i++) begin
         fnum = 10'($urandom_range(0, 1023)); zero = 1'b1; lfo_rst = 1'(i);
         tick();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL cen_hold_valid i=%0d got=%b exp=0", i, out_valid); end
         checks++;
         if (pm_offset !== held) begin errors++; $display("FAIL cen_hold_offset i=%0d got=%h exp=%h", i, pm_offset, held); end
      end
      idle_inputs();
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL cen_resume_valid got=%b exp=1", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL cen_pulse_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_rst_priority();
      clear_lfo();
      pulses(3 * PERIOD + PERIOD - 1);   // prescaler = 1023, step = 3
      checks++;
      if (vib_cnt !== 3'd3) begin errors++; $display("FAIL prio_setup got=%0d exp=3", vib_cnt); end
      zero = 1'b1; lfo_rst = 1'b1;
      tick();
      lfo_rst = 1'b0; zero = 1'b0;
      checks++;
      if (vib_cnt !== 3'd0) begin errors++; $display("FAIL prio_rst got=%0d exp=0", vib_cnt); end
      pulses(PERIOD - 1);                // prescaler must have restarted from 0
      checks++;
      if (vib_cnt !== 3'd0) begin errors++; $display("FAIL prio_presc got=%0d exp=0", vib_cnt); end
      pulses(1);
      checks++;
      if (vib_cnt !== 3'd1) begin errors++; $display("FAIL prio_wrap got=%0d exp=1", vib_cnt); end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 12000; i++) begin
         cen      = ($urandom_range(0, 3) != 0);
         zero     = ($urandom_range(0, 9) != 0);
         lfo_rst  = ($urandom_range(0, 2999) == 0);
         vib_dep  = 1'($urandom);
         viben    = ($urandom_range(0, 3) != 0);
         in_valid = 1'($urandom);
         fnum     = 10'($urandom);
`ifdef JTOPL_PM_LFO_LOAD_EN
         lfo_load = ($urandom_range(0, 499) == 0);
         lfo_din  = 3'($urandom);
`endif
         tick();
         checks++;
         if (pm_offset !== exp_off || out_valid !== exp_val || vib_cnt !== 3'(model_step())) begin
            errors++;
            $display("FAIL random i=%0d got=%h/%b/%0d exp=%h/%b/%0d", i, pm_offset, out_valid,
                     vib_cnt, exp_off, exp_val, model_step());
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      clear_lfo();
      pulses(2 * PERIOD);
      fnum = 10'h380; vib_dep = 1'b1; viben = 1'b1; in_valid = 1'b1;
      tick(); tick();
      checks++;
      if (pm_offset !== 4'h7 || out_valid !== 1'b1) begin
         errors++; $display("FAIL arst_setup got=%h/%b exp=7/1", pm_offset, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pm_offset !== '0 || out_valid !== 1'b0 || vib_cnt !== 3'd0) begin
         errors++; $display("FAIL arst_async got=%h/%b/%0d exp=0/0/0", pm_offset, out_valid, vib_cnt);
      end
      model_reset();
      #2 rst_n = 1'b1;
      in_valid = 1'b0;
   endtask

`ifdef JTOPL_PM_LFO_LOAD_EN
   task automatic test_load();
      idle_inputs();
      lfo_load = 1'b1; lfo_din = 3'd6; zero = 1'b1;
      tick();
      lfo_load = 1'b0; zero = 1'b0;
      checks++;
      if (vib_cnt !== 3'd6) begin errors++; $display("FAIL load got=%0d exp=6", vib_cnt); end
      lfo_rst = 1'b1; lfo_load = 1'b1; lfo_din = 3'd5;
      tick();
      lfo_rst = 1'b0; lfo_load = 1'b0;
      checks++;
      if (vib_cnt !== 3'd0) begin errors++; $display("FAIL load_prio got=%0d exp=0", vib_cnt); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lfo_count();
      test_vib_sequence();
      test_cen_hold();
      test_rst_priority();
      test_async_reset();
`ifdef JTOPL_PM_LFO_LOAD_EN
      test_load();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
